// File: rtl/pcie_dw_completer.sv
// pcie_dw_completer: BAR0 1-DW MRd32/MWr32 responder on the VC0 user interface.
// Ports: sys_clk_125/rst_n/dl_up, rx_* TLP in, tx_* CplD out, tx_ca_* credits,
//        bus/dev/func ID, *_processed_vc0 credit releases, nph_buf_status_vc0.
module pcie_dw_completer #(
  parameter int REG_AW = 4
) (
  input  logic        sys_clk_125,
  input  logic        rst_n,
  input  logic        dl_up,
  input  logic [15:0] rx_data_vc0,
  input  logic        rx_st_vc0,
  input  logic        rx_end_vc0,
  input  logic [6:0]  rx_bar_hit,
  output logic        tx_req_vc0,
  input  logic        tx_rdy_vc0,
  output logic [15:0] tx_data_vc0,
  output logic        tx_st_vc0,
  output logic        tx_end_vc0,
  output logic        tx_nlfy_vc0,
  input  logic [8:0]  tx_ca_cplh_vc0,
  input  logic [12:0] tx_ca_cpld_vc0,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  output logic        ph_processed_vc0,
  output logic        pd_processed_vc0,
  output logic        nph_processed_vc0,
  output logic        nph_buf_status_vc0
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND
  } tx_state_e;

  // rx parser
  logic        in_pkt_q, in_pkt_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  widx;
  logic        bar0_q, bar0_d;
  logic [7:0]  ft_q, ft_d;
  logic [2:0]  tc_q, tc_d;
  logic [1:0]  attr_q, attr_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [13:0] alo_q, alo_d;
  logic [15:0] dhi_q, dhi_d;
  logic [15:0] dlo_q, dlo_d;

  logic rx_word;
  logic end_fire;
  logic mwr_any;
  logic mrd_any;
  logic hit1;
  logic wr_fire;
  logic rd_fire;
  logic disc_fire;
  logic [REG_AW-1:0] wr_idx;

  // pending non-posted slot
  logic              slot_q, slot_d;
  logic [15:0]       s_rid_q, s_rid_d;
  logic [7:0]        s_tag_q, s_tag_d;
  logic [2:0]        s_tc_q, s_tc_d;
  logic [1:0]        s_attr_q, s_attr_d;
  logic [4:0]        s_alo_q, s_alo_d;
  logic [REG_AW-1:0] s_ridx_q, s_ridx_d;

  // tx side
  tx_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cpl_word;
  logic        tx_end_now;

  // register file
  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];

  // credit releases
  logic       pw_rel_q, pw_rel_d;
  logic [1:0] disc_cnt_q, disc_cnt_d;
  logic       disc_dec;

  logic unused_ok;
  assign unused_ok = ^{rx_bar_hit[6:1], alo_d[13:5]};

  // ---------------- rx parser ----------------
  always_comb begin
    widx    = rx_st_vc0 ? 4'd0 : wcnt_q;
    rx_word = dl_up & (rx_st_vc0 | in_pkt_q);
    bar0_d  = bar0_q;
    ft_d    = ft_q;
    tc_d    = tc_q;
    attr_d  = attr_q;
    len_d   = len_q;
    rid_d   = rid_q;
    tag_d   = tag_q;
    alo_d   = alo_q;
    dhi_d   = dhi_q;
    dlo_d   = dlo_q;
    if (rx_st_vc0) begin
      bar0_d = rx_bar_hit[0];
    end
    if (rx_word) begin
      case (widx)
        4'd0: begin
          ft_d = rx_data_vc0[15:8];
          tc_d = rx_data_vc0[6:4];
        end
        4'd1: begin
          attr_d = rx_data_vc0[13:12];
          len_d  = rx_data_vc0[9:0];
        end
        4'd2: rid_d = rx_data_vc0;
        4'd3: tag_d = rx_data_vc0[15:8];
        4'd5: alo_d = rx_data_vc0[15:2];
        4'd6: dhi_d = rx_data_vc0;
        4'd7: dlo_d = rx_data_vc0;
        default: ;
      endcase
    end

    in_pkt_d = in_pkt_q;
    wcnt_d   = wcnt_q;
    if (!dl_up) begin
      in_pkt_d = 1'b0;
      wcnt_d   = 4'd0;
    end else if (rx_word && rx_end_vc0) begin
      in_pkt_d = 1'b0;
    end else if (rx_st_vc0) begin
      in_pkt_d = 1'b1;
      wcnt_d   = 4'd1;
    end else if (in_pkt_q && wcnt_q != 4'hf) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // decode on the last word, using the field values that include it
  always_comb begin
    end_fire  = rx_word & rx_end_vc0;
    mwr_any   = (ft_d == 8'h40) || (ft_d == 8'h60);
    mrd_any   = (ft_d == 8'h00) || (ft_d == 8'h20);
    hit1      = bar0_d && (len_d == 10'd1);
    wr_fire   = end_fire && (ft_d == 8'h40) && hit1;
    rd_fire   = end_fire && (ft_d == 8'h00) && hit1 && !slot_q;
    disc_fire = end_fire && mrd_any && !rd_fire;
    wr_idx    = alo_d[REG_AW-1:0];
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[wr_idx] = {dhi_d, dlo_d};
    end
  end

  // ---------------- tx fsm ----------------
  assign tx_end_now = (state_q == TX_SEND) && (cnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    slot_d   = slot_q;
    s_rid_d  = s_rid_q;
    s_tag_d  = s_tag_q;
    s_tc_d   = s_tc_q;
    s_attr_d = s_attr_q;
    s_alo_d  = s_alo_q;
    s_ridx_d = s_ridx_q;

    unique case (state_q)
      TX_IDLE: begin
        if (slot_q && tx_ca_cplh_vc0 != '0 && tx_ca_cpld_vc0 != '0) begin
          state_d = TX_REQ;
          // read before any same-edge write lands
          rdata_d = regs_q[s_ridx_q];
        end
      end
      TX_REQ: begin
        if (tx_rdy_vc0) begin
          state_d = TX_SEND;
          cnt_d   = 3'd0;
        end
      end
      TX_SEND: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = TX_IDLE;
          slot_d  = 1'b0;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (rd_fire) begin
      slot_d   = 1'b1;
      s_rid_d  = rid_d;
      s_tag_d  = tag_d;
      s_tc_d   = tc_d;
      s_attr_d = attr_d;
      s_alo_d  = alo_d[4:0];
      s_ridx_d = alo_d[REG_AW-1:0];
    end

    if (!dl_up) begin
      state_d = TX_IDLE;
      cnt_d   = 3'd0;
      slot_d  = 1'b0;
    end
  end

  always_comb begin
    cpl_word = '0;
    unique case (cnt_q)
      3'd0: cpl_word = {8'h4A, 1'b0, s_tc_q, 4'h0};
      3'd1: cpl_word = {2'b00, s_attr_q, 2'b00, 10'd1};
      3'd2: cpl_word = {bus_num, dev_num, func_num};
      3'd3: cpl_word = {3'b000, 1'b0, 12'd4};
      3'd4: cpl_word = s_rid_q;
      3'd5: cpl_word = {s_tag_q, 1'b0, s_alo_q, 2'b00};
      3'd6: cpl_word = rdata_q[31:16];
      3'd7: cpl_word = rdata_q[15:0];
      default: cpl_word = '0;
    endcase
  end

  // ---------------- credit release ----------------
  // completion release owns the cycle; a queued discard release waits
  always_comb begin
    pw_rel_d   = end_fire && mwr_any;
    disc_dec   = (disc_cnt_q != 2'd0) && !tx_end_now;
    disc_cnt_d = disc_cnt_q + {1'b0, disc_fire} - {1'b0, disc_dec};
    if (!dl_up) begin
      pw_rel_d   = 1'b0;
      disc_cnt_d = 2'd0;
    end
  end

  // ---------------- outputs ----------------
  assign tx_req_vc0  = dl_up && (state_q == TX_REQ);
  assign tx_st_vc0   = dl_up && (state_q == TX_SEND) && (cnt_q == 3'd0);
  assign tx_end_vc0  = dl_up && tx_end_now;
  assign tx_data_vc0 = (dl_up && state_q == TX_SEND) ? cpl_word : 16'h0;
  assign tx_nlfy_vc0 = 1'b0;

  assign ph_processed_vc0   = dl_up && pw_rel_q;
  assign pd_processed_vc0   = dl_up && pw_rel_q;
  assign nph_processed_vc0  = dl_up && (tx_end_now || disc_cnt_q != 2'd0);
  assign nph_buf_status_vc0 = dl_up && slot_q && !tx_end_now;

  // ---------------- state ----------------
  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt_q   <= 1'b0;
      wcnt_q     <= 4'd0;
      bar0_q     <= 1'b0;
      ft_q       <= 8'h0;
      tc_q       <= 3'd0;
      attr_q     <= 2'd0;
      len_q      <= 10'd0;
      rid_q      <= 16'h0;
      tag_q      <= 8'h0;
      alo_q      <= 14'h0;
      dhi_q      <= 16'h0;
      dlo_q      <= 16'h0;
      slot_q     <= 1'b0;
      s_rid_q    <= 16'h0;
      s_tag_q    <= 8'h0;
      s_tc_q     <= 3'd0;
      s_attr_q   <= 2'd0;
      s_alo_q    <= 5'd0;
      s_ridx_q   <= '0;
      state_q    <= TX_IDLE;
      cnt_q      <= 3'd0;
      rdata_q    <= 32'h0;
      pw_rel_q   <= 1'b0;
      disc_cnt_q <= 2'd0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      in_pkt_q   <= in_pkt_d;
      wcnt_q     <= wcnt_d;
      bar0_q     <= bar0_d;
      ft_q       <= ft_d;
      tc_q       <= tc_d;
      attr_q     <= attr_d;
      len_q      <= len_d;
      rid_q      <= rid_d;
      tag_q      <= tag_d;
      alo_q      <= alo_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
      slot_q     <= slot_d;
      s_rid_q    <= s_rid_d;
      s_tag_q    <= s_tag_d;
      s_tc_q     <= s_tc_d;
      s_attr_q   <= s_attr_d;
      s_alo_q    <= s_alo_d;
      s_ridx_q   <= s_ridx_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      pw_rel_q   <= pw_rel_d;
      disc_cnt_q <= disc_cnt_d;
      regs_q     <= regs_d;
    end
  end

endmodule

// File: tb/tb_pcie_dw_completer.sv
// tb_pcie_dw_completer: directed self-checking bench for pcie_dw_completer.
// Drives MRd32/MWr32 TLPs, services the tx handshake, checks CplD and releases.
module tb_pcie_dw_completer;

  logic        sys_clk_125 = 1'b0;
  logic        rst_n;
  logic        dl_up;
  logic [15:0] rx_data_vc0;
  logic        rx_st_vc0;
  logic        rx_end_vc0;
  logic [6:0]  rx_bar_hit;
  logic        tx_req_vc0;
  logic        tx_rdy_vc0;
  logic [15:0] tx_data_vc0;
  logic        tx_st_vc0;
  logic        tx_end_vc0;
  logic        tx_nlfy_vc0;
  logic [8:0]  tx_ca_cplh_vc0;
  logic [12:0] tx_ca_cpld_vc0;
  logic [7:0]  bus_num;
  logic [4:0]  dev_num;
  logic [2:0]  func_num;
  logic        ph_processed_vc0;
  logic        pd_processed_vc0;
  logic        nph_processed_vc0;
  logic        nph_buf_status_vc0;

  always #4 sys_clk_125 = ~sys_clk_125;

  pcie_dw_completer #(.REG_AW(4)) dut (
    .sys_clk_125        (sys_clk_125),
    .rst_n              (rst_n),
    .dl_up              (dl_up),
    .rx_data_vc0        (rx_data_vc0),
    .rx_st_vc0          (rx_st_vc0),
    .rx_end_vc0         (rx_end_vc0),
    .rx_bar_hit         (rx_bar_hit),
    .tx_req_vc0         (tx_req_vc0),
    .tx_rdy_vc0         (tx_rdy_vc0),
    .tx_data_vc0        (tx_data_vc0),
    .tx_st_vc0          (tx_st_vc0),
    .tx_end_vc0         (tx_end_vc0),
    .tx_nlfy_vc0        (tx_nlfy_vc0),
    .tx_ca_cplh_vc0     (tx_ca_cplh_vc0),
    .tx_ca_cpld_vc0     (tx_ca_cpld_vc0),
    .bus_num            (bus_num),
    .dev_num            (dev_num),
    .func_num           (func_num),
    .ph_processed_vc0   (ph_processed_vc0),
    .pd_processed_vc0   (pd_processed_vc0),
    .nph_processed_vc0  (nph_processed_vc0),
    .nph_buf_status_vc0 (nph_buf_status_vc0)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] tw [8];
  int          tw_n;

  logic [15:0] cw [8];
  logic [7:0]  st_bits, end_bits, nph_bits;
  logic        req_during, nph_after, buf_after;
  int          req_cycles;
  bit          buf_ok, cpl_to;

  task automatic step();
    @(posedge sys_clk_125);
    #1;
  endtask

  task automatic build_tlp(input logic [7:0] ft, input logic [2:0] tc,
                           input logic [1:0] attr, input logic [9:0] len,
                           input logic [15:0] rid, input logic [7:0] tag,
                           input logic [31:0] addr, input logic [31:0] data);
    tw[0] = {ft, 1'b0, tc, 4'h0};
    tw[1] = {2'b00, attr, 2'b00, len};
    tw[2] = rid;
    tw[3] = {tag, 8'h0F};
    tw[4] = addr[31:16];
    tw[5] = addr[15:0];
    tw[6] = data[31:16];
    tw[7] = data[15:0];
    tw_n  = (ft == 8'h40) ? 8 : 6;
  endtask

  // returns in the cycle after rx_end
  task automatic send_tlp(input logic bar0, input bit cred_on_end);
    for (int i = 0; i < tw_n; i++) begin
      rx_data_vc0 = tw[i];
      rx_st_vc0   = (i == 0);
      rx_end_vc0  = (i == tw_n - 1);
      rx_bar_hit  = (i == 0) ? {6'b0, bar0} : 7'b0;
      if (cred_on_end && i == tw_n - 1) tx_ca_cplh_vc0 = 9'd8;
      step();
    end
    rx_data_vc0 = 16'h0;
    rx_st_vc0   = 1'b0;
    rx_end_vc0  = 1'b0;
    rx_bar_hit  = 7'b0;
  endtask

  task automatic get_cpl(input int rdy_delay);
    int k;
    k = 0;
    cpl_to = 0;
    req_cycles = 0;
    buf_ok = 1;
    st_bits = '0;
    end_bits = '0;
    nph_bits = '0;
    req_during = 1'b0;
    while (tx_req_vc0 !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    if (tx_req_vc0 !== 1'b1) begin
      cpl_to = 1;
      return;
    end
    for (int i = 0; i < rdy_delay; i++) begin
      if (tx_req_vc0 === 1'b1) req_cycles++;
      if (nph_buf_status_vc0 !== 1'b1) buf_ok = 0;
      step();
    end
    tx_rdy_vc0 = 1'b1;
    step();
    tx_rdy_vc0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cw[i]       = tx_data_vc0;
      st_bits[i]  = tx_st_vc0;
      end_bits[i] = tx_end_vc0;
      nph_bits[i] = nph_processed_vc0;
      req_during  = req_during | tx_req_vc0;
      step();
    end
    nph_after = nph_processed_vc0;
    buf_after = nph_buf_status_vc0;
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    outs = {tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0,
            ph_processed_vc0, pd_processed_vc0,
            nph_processed_vc0, nph_buf_status_vc0};
    checks++;
    if (outs !== 8'h00 || tx_data_vc0 !== 16'h0) begin
      failures++;
      $display("FAIL reset_outs: got %b data %h want 0", outs, tx_data_vc0);
    end
    rst_n = 1'b1;
    step();
    step();
    outs = {tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0,
            ph_processed_vc0, pd_processed_vc0,
            nph_processed_vc0, nph_buf_status_vc0};
    checks++;
    if (outs !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_outs: got %b want 0", outs);
    end
    // cleared register file reads back zero
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h01, 32'hC, 32'h0);
    send_tlp(1'b1, 1'b0);
    get_cpl(0);
    checks++;
    if (cpl_to || {cw[6], cw[7]} !== 32'h0) begin
      failures++;
      $display("FAIL reset_reg3: got %h%h to=%0d want 00000000",
               cw[6], cw[7], cpl_to);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] exp_w [8];
    build_tlp(8'h40, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h00, 32'h8, 32'hDEADBEEF);
    send_tlp(1'b1, 1'b0);
    checks++;
    if ({ph_processed_vc0, pd_processed_vc0, nph_processed_vc0} !== 3'b110) begin
      failures++;
      $display("FAIL mwr_release: got ph/pd/nph %b%b%b want 110",
               ph_processed_vc0, pd_processed_vc0, nph_processed_vc0);
    end
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h05, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    checks++;
    if (nph_buf_status_vc0 !== 1'b1 || nph_processed_vc0 !== 1'b0) begin
      failures++;
      $display("FAIL mrd_accept: got buf %b nph %b want 1 0",
               nph_buf_status_vc0, nph_processed_vc0);
    end
    get_cpl(0);
    exp_w = '{16'h4A00, 16'h0001, 16'h0100, 16'h0004,
              16'h0100, 16'h0508, 16'hDEAD, 16'hBEEF};
    checks++;
    if (cpl_to) begin
      failures++;
      $display("FAIL cpl1_timeout: got no tx_req want tx_req");
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cw[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL cpl1_w%0d: got %h want %h", i, cw[i], exp_w[i]);
      end
    end
    checks++;
    if (st_bits !== 8'h01 || end_bits !== 8'h80 || req_during !== 1'b0) begin
      failures++;
      $display("FAIL cpl1_framing: got st %b end %b req %b want 01 80 0",
               st_bits, end_bits, req_during);
    end
    checks++;
    if (nph_bits !== 8'h80 || nph_after !== 1'b0 || buf_after !== 1'b0) begin
      failures++;
      $display("FAIL cpl1_nph: got nph %b after %b buf %b want 80 0 0",
               nph_bits, nph_after, buf_after);
    end
    // reg 5, nonzero TC/attr, different completer ID
    bus_num = 8'h12;
    dev_num = 5'd3;
    func_num = 3'd5;
    build_tlp(8'h40, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h00, 32'h14, 32'h0BADF00D);
    send_tlp(1'b1, 1'b0);
    build_tlp(8'h00, 3'd3, 2'd2, 10'd1, 16'h0A0B, 8'h06, 32'h14, 32'h0);
    send_tlp(1'b1, 1'b0);
    get_cpl(0);
    exp_w = '{16'h4A30, 16'h2001, 16'h121D, 16'h0004,
              16'h0A0B, 16'h0614, 16'h0BAD, 16'hF00D};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cpl_to || cw[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL cpl2_w%0d: got %h want %h", i, cw[i], exp_w[i]);
      end
    end
    bus_num = 8'h01;
    dev_num = 5'd0;
    func_num = 3'd0;
  endtask

  task automatic test_rdy_stall();
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h11, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    get_cpl(20);
    checks++;
    if (cpl_to || req_cycles != 20 || !buf_ok) begin
      failures++;
      $display("FAIL stall_req: got req %0d buf_ok %0d to %0d want 20 1 0",
               req_cycles, buf_ok, cpl_to);
    end
    checks++;
    if (st_bits !== 8'h01 || {cw[6], cw[7]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL stall_cpl: got st %b data %h%h want 01 deadbeef",
               st_bits, cw[6], cw[7]);
    end
  endtask

  task automatic test_no_credit();
    logic seen;
    tx_ca_cplh_vc0 = 9'd0;
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h21, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= tx_req_vc0;
      step();
    end
    checks++;
    if (seen !== 1'b0 || nph_buf_status_vc0 !== 1'b1) begin
      failures++;
      $display("FAIL no_cplh: got req %b buf %b want 0 1",
               seen, nph_buf_status_vc0);
    end
    tx_ca_cplh_vc0 = 9'd8;
    tx_ca_cpld_vc0 = 13'd0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= tx_req_vc0;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL no_cpld: got req %b want 0", seen);
    end
    tx_ca_cpld_vc0 = 13'd64;
    get_cpl(0);
    checks++;
    if (cpl_to || cw[5] !== 16'h2108) begin
      failures++;
      $display("FAIL credit_cpl: got w5 %h to %0d want 2108", cw[5], cpl_to);
    end
  endtask

  task automatic test_discard();
    logic seen;
    build_tlp(8'h00, 3'd0, 2'd0, 10'd2, 16'h0100, 8'h31, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    checks++;
    if (nph_processed_vc0 !== 1'b1 || nph_buf_status_vc0 !== 1'b0) begin
      failures++;
      $display("FAIL disc_mrd: got nph %b buf %b want 1 0",
               nph_processed_vc0, nph_buf_status_vc0);
    end
    step();
    checks++;
    if (nph_processed_vc0 !== 1'b0) begin
      failures++;
      $display("FAIL disc_mrd_pulse: got nph %b want 0", nph_processed_vc0);
    end
    build_tlp(8'h40, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h00, 32'h8, 32'h12345678);
    send_tlp(1'b0, 1'b0);
    checks++;
    if ({ph_processed_vc0, pd_processed_vc0, nph_processed_vc0} !== 3'b110) begin
      failures++;
      $display("FAIL disc_mwr_rel: got ph/pd/nph %b%b%b want 110",
               ph_processed_vc0, pd_processed_vc0, nph_processed_vc0);
    end
    build_tlp(8'h40, 3'd0, 2'd0, 10'd2, 16'h0100, 8'h00, 32'h8, 32'h55AA55AA);
    send_tlp(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= tx_req_vc0;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL disc_no_cpl: got req %b want 0", seen);
    end
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h32, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    get_cpl(0);
    checks++;
    if (cpl_to || {cw[6], cw[7]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL disc_reg: got %h%h want deadbeef", cw[6], cw[7]);
    end
  endtask

  task automatic test_dl_down();
    int k;
    logic seen;
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h41, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    k = 0;
    while (tx_req_vc0 !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (tx_req_vc0 !== 1'b1) begin
      failures++;
      $display("FAIL dl_req: got %b want 1", tx_req_vc0);
    end
    tx_rdy_vc0 = 1'b1;
    step();
    tx_rdy_vc0 = 1'b0;
    step();
    step();
    step();
    checks++;
    if (tx_data_vc0 !== 16'h0004) begin
      failures++;
      $display("FAIL dl_w3: got %h want 0004", tx_data_vc0);
    end
    dl_up = 1'b0;
    step();
    checks++;
    if ({tx_st_vc0, tx_end_vc0, tx_req_vc0, nph_buf_status_vc0,
         nph_processed_vc0} !== 5'b0) begin
      failures++;
      $display("FAIL dl_drop: got st/end/req/buf/nph %b%b%b%b%b want 00000",
               tx_st_vc0, tx_end_vc0, tx_req_vc0, nph_buf_status_vc0,
               nph_processed_vc0);
    end
    step();
    dl_up = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= tx_req_vc0 | nph_processed_vc0 | nph_buf_status_vc0 | tx_st_vc0;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL dl_flush: got activity %b want 0", seen);
    end
  endtask

  task automatic test_same_cycle();
    tx_ca_cplh_vc0 = 9'd0;
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h51, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    step();
    build_tlp(8'h40, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h00, 32'h8, 32'hCAFEF00D);
    send_tlp(1'b1, 1'b1);
    checks++;
    if (tx_req_vc0 !== 1'b1) begin
      failures++;
      $display("FAIL same_req: got %b want 1", tx_req_vc0);
    end
    get_cpl(0);
    checks++;
    if (cpl_to || {cw[6], cw[7]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL same_old: got %h%h want deadbeef", cw[6], cw[7]);
    end
    build_tlp(8'h00, 3'd0, 2'd0, 10'd1, 16'h0100, 8'h52, 32'h8, 32'h0);
    send_tlp(1'b1, 1'b0);
    get_cpl(0);
    checks++;
    if (cpl_to || {cw[6], cw[7]} !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL same_new: got %h%h want cafef00d", cw[6], cw[7]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dl_up = 1'b1;
    rx_data_vc0 = 16'h0;
    rx_st_vc0 = 1'b0;
    rx_end_vc0 = 1'b0;
    rx_bar_hit = 7'b0;
    tx_rdy_vc0 = 1'b0;
    tx_ca_cplh_vc0 = 9'd8;
    tx_ca_cpld_vc0 = 13'd64;
    bus_num = 8'h01;
    dev_num = 5'd0;
    func_num = 3'd0;
    repeat (3) step();
    test_reset();
    test_write_read();
    test_rdy_stall();
    test_no_credit();
    test_discard();
    test_dl_down();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_dw_completer.md
Name: pcie_dw_completer

Overview:
- User-side responder on the VC0 TLP interface of the x1 PCIe endpoint core.
- Parses received MRd32/MWr32 TLPs hitting BAR0 and writes 1-DW MWr data into an internal register file.
- For each 1-DW MRd, returns a single CplD TLP over the core's tx_req/tx_rdy transmit handshake.
- Also generates the core's receive-credit release pulses and the non-posted-buffer-full indication.

Parameters:
- REG_AW, 4, register-file address width; 2**REG_AW 32-bit registers, indexed by TLP address[REG_AW+1:2].

Ports:
- sys_clk_125  in  1  core user clock, 125 MHz
- rst_n  in  1  reset; asynchronous, active-low
- dl_up  in  1  data link up; low flushes all state
- rx_data_vc0  in  16  received TLP word
- rx_st_vc0  in  1  first word of TLP
- rx_end_vc0  in  1  last word of TLP
- rx_bar_hit  in  7  BAR hit vector, valid with rx_st_vc0; bit0 used
- tx_req_vc0  out  1  transmit request
- tx_rdy_vc0  in  1  core grants transmit
- tx_data_vc0  out  16  transmit word
- tx_st_vc0  out  1  first transmit word
- tx_end_vc0  out  1  last transmit word
- tx_nlfy_vc0  out  1  nullify; tied 0
- tx_ca_cplh_vc0  in  9  completion header credits
- tx_ca_cpld_vc0  in  13  completion data credits
- bus_num  in  8  completer bus number
- dev_num  in  5  completer device number
- func_num  in  3  completer function number
- ph_processed_vc0  out  1  posted header released, 1-cycle pulse
- pd_processed_vc0  out  1  posted data released, 1-cycle pulse
- nph_processed_vc0  out  1  non-posted header released, 1-cycle pulse
- nph_buf_status_vc0  out  1  non-posted slot full

Behaviour:
- Reset values: all outputs 0; register file cleared to 0; both FSMs in IDLE.
- RX parser word counter:
  - Cleared on rx_st_vc0, then increments once per cycle until rx_end_vc0.
  - Captured fields:
    - w0[15:8]: fmt/type
    - w0[6:4]: TC
    - w1[13:12]: attr
    - w1[9:0]: length
    - w2: requester ID
    - w3[15:8]: tag
    - w4: addr[31:16]
    - w5[15:2]: addr[15:2]
    - w6/w7: data[31:16]/[15:0]
  - Big-endian word order: data[31:16] carries the first payload word.
- MWr32 (fmt/type 8'h40) with length==1 and bar_hit[0]: register write committed the cycle after rx_end_vc0.
- MRd32 (fmt/type 8'h00) with length==1 and bar_hit[0]: request (req ID, tag, TC, attr, addr[6:2], reg index) loaded into the single pending slot the cycle after rx_end_vc0.
- Any other TLP (other type, length≠1, no BAR0 hit) is discarded with no register effect and no completion.
- Credit release, one cycle after rx_end_vc0:
  - MWr (any): ph_processed_vc0 pulse plus pd_processed_vc0 pulse.
  - Discarded MRd-class (fmt/type 8'h00/8'h20): nph_processed_vc0 pulse.
  - Accepted MRd: nph_processed_vc0 pulses at tx_end_vc0 of its completion.
- nph_buf_status_vc0 is 1 while the pending slot is occupied; the core holds further non-posted TLPs.
- TX FSM states: IDLE → REQ → SEND → IDLE.
  - IDLE→REQ: slot full, tx_ca_cplh_vc0≠0 and tx_ca_cpld_vc0≠0. Register read data is sampled here.
  - REQ: tx_req_vc0=1 until tx_rdy_vc0 is sampled high.
  - SEND: entered the cycle after tx_rdy_vc0. tx_req_vc0 drops with tx_st_vc0. One word per cycle, 8 words, tx_end_vc0 on word 7. Slot freed the same cycle.
- CplD words 0-7:
  - {8'h4A,1'b0,TC,4'h0}
  - {2'b00,attr,2'b00,10'd1}
  - {bus_num,dev_num,func_num}
  - {3'b000,1'b0,12'd4}
  - requester ID
  - {tag,1'b0,addr[6:2],2'b00}
  - data[31:16]
  - data[15:0]
- Simultaneous events:
  - MWr to the register being completed in the same cycle as IDLE→REQ: the old value is returned (data sampled before the write).
  - RX TLP end coinciding with tx_end_vc0: both processed pulses issue. nph_processed_vc0 takes priority; a discard-release already pending is delayed one cycle.
- dl_up low: FSMs to IDLE, slot cleared, tx_* deasserted immediately, no processed pulses. The register file is retained.
- rst_n assertion mid-packet: all state returns to reset values asynchronously.

Test Plan:
- MWr32 addr 0x0000_0008, data 0xDEADBEEF, then MRd32 addr 0x8, tag 0x05, req ID 0x0100, bus/dev/func 1/0/0 → CplD words 4A00,0001,0100,0004,0100,0508,DEAD,BEEF; nph_processed one pulse at tx_end.
- MRd with tx_rdy held low 20 cycles → tx_req_vc0 held high 20 cycles, tx_st exactly one cycle after tx_rdy rises, nph_buf_status=1 throughout.
- tx_ca_cplh_vc0=0 for 10 cycles → no tx_req_vc0 until credits are non-zero.
- MRd length=2 and MWr with bar_hit=0 → no completion, no register change, nph_processed and ph/pd_processed pulses one cycle after rx_end.
- dl_up dropped mid-SEND at word 3 → tx_st/tx_end/tx_req low next cycle, nph_buf_status=0, no nph_processed.
- MWr to reg 2 ending on the same cycle as IDLE→REQ for a read of reg 2 → completion returns the prior value.
